// File: rtl/xz_sanitizer.sv
// xz_sanitizer: single-stage valid/ready register that scrubs X/Z bits from
// 4-state upstream data, reports where they were, counts flagged beats and
// optionally halts intake until software acknowledges with clr_err.
module xz_sanitizer #(
    parameter int   WIDTH      = 32,
    parameter logic FILL       = 1'b0,
    parameter int   STOP_ON_XZ = 1,
    parameter int   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output bit   [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_xz_mask,
    output logic             out_xz_flag,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] xz_count,
    output logic             halted
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             in_valid_ok;
    logic             out_ready_ok;
    logic             clr_ok;
    logic             accept;
    logic             accept_xz;
    logic [WIDTH-1:0] beat_mask;
    bit   [WIDTH-1:0] beat_clean;

    // Unknown handshake/control inputs are treated as deasserted.
    assign in_valid_ok  = (in_valid === 1'b1);
    assign out_ready_ok = (out_ready === 1'b1);
    assign clr_ok       = (clr_err === 1'b1);

    assign in_ready  = (!out_valid || out_ready_ok) && (state == RUN) && !rst;
    assign accept    = in_valid_ok && in_ready;
    assign accept_xz = accept && (|beat_mask);
    assign halted    = (state == HALT);

    // Per-bit classification: known bits pass through, X/Z bits become FILL.
    always_comb begin
        beat_mask  = '0;
        beat_clean = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((in_data[i] === 1'b0) || (in_data[i] === 1'b1)) begin
                beat_clean[i] = in_data[i];
                beat_mask[i]  = 1'b0;
            end else begin
                beat_clean[i] = FILL;
                beat_mask[i]  = 1'b1;
            end
        end
    end

    // Output register: load on accept, drop valid when drained without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_xz_mask <= '0;
            out_xz_flag <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= beat_clean;
            out_xz_mask <= beat_mask;
            out_xz_flag <= |beat_mask;
        end else if (out_ready_ok) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of accepted beats that carried any X/Z bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xz_count <= '0;
        end else if (accept_xz && (xz_count != {CNT_W{1'b1}})) begin
            xz_count <= xz_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky error: a new flagged beat outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (accept_xz) begin
            err_sticky <= 1'b1;
        end else if (clr_ok) begin
            err_sticky <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: halt on a flagged beat (if enabled), resume on clr_err.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (accept_xz && (STOP_ON_XZ != 0)) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (clr_ok) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_xz_sanitizer.sv
// Directed bench for xz_sanitizer: a transaction-level reference model checked
// every cycle against instance u0, plus literal expectations for both instances.
module tb_xz_sanitizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // u0: defaults (FILL=0, STOP_ON_XZ=1, CNT_W=16)
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    bit   [31:0] out_data;
    logic [31:0] out_xz_mask;
    logic        out_xz_flag;
    logic        clr_err = 1'b0;
    logic        err_sticky;
    logic [15:0] xz_count;
    logic        halted;

    // u1: FILL=1, STOP_ON_XZ=0, CNT_W=2
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [31:0] in_data1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    bit   [31:0] out_data1;
    logic [31:0] out_xz_mask1;
    logic        out_xz_flag1;
    logic        clr_err1 = 1'b0;
    logic        err_sticky1;
    logic [1:0]  xz_count1;
    logic        halted1;

    int checks = 0;
    int errors = 0;
    logic four_state;
    logic probe;

    always #5 clk = ~clk;

    xz_sanitizer u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_xz_mask(out_xz_mask), .out_xz_flag(out_xz_flag),
        .clr_err(clr_err), .err_sticky(err_sticky), .xz_count(xz_count),
        .halted(halted)
    );

    xz_sanitizer #(.WIDTH(32), .FILL(1'b1), .STOP_ON_XZ(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_xz_mask(out_xz_mask1), .out_xz_flag(out_xz_flag1),
        .clr_err(clr_err1), .err_sticky(err_sticky1), .xz_count(xz_count1),
        .halted(halted1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model for u0: what the registered output must hold.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_mask  = '0;
    logic [15:0] m_cnt   = '0;
    logic        m_err   = 1'b0;
    logic        m_halt  = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic acc;
        logic xz;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_mask = '0;
            m_cnt = '0; m_err = 1'b0; m_halt = 1'b0;
        end else begin
            acc = (in_valid === 1'b1) && (!m_valid || (out_ready === 1'b1)) && !m_halt;
            xz  = acc && $isunknown(in_data);
            if (acc) begin
                m_valid = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    m_mask[i] = $isunknown(in_data[i]);
                    m_data[i] = m_mask[i] ? 1'b0 : in_data[i];
                end
            end else if (out_ready === 1'b1) begin
                m_valid = 1'b0;
            end
            if (xz && (m_cnt < 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            if (xz) m_err = 1'b1;
            else if (clr_err === 1'b1) m_err = 1'b0;
            if (xz) m_halt = 1'b1;
            else if (clr_err === 1'b1) m_halt = 1'b0;
        end
    end

    // Per-cycle comparison of u0 against the model.
    always @(negedge clk) begin
        chk("mdl_out_valid", out_valid, m_valid);
        chk("mdl_out_data", out_data, m_data);
        chk("mdl_mask", out_xz_mask, m_mask);
        chk("mdl_flag", out_xz_flag, |m_mask);
        chk("mdl_err", err_sticky, m_err);
        chk("mdl_count", xz_count, m_cnt);
        chk("mdl_halted", halted, m_halt);
        chk("mdl_in_ready", in_ready,
            (!m_valid || (out_ready === 1'b1)) && !m_halt && !rst);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        probe = 1'bx;
        four_state = $isunknown(probe);

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_count", xz_count, 16'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Clean beat
        in_valid = 1'b1; in_data = 32'h0000_0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("clean_valid", out_valid, 1'b1);
        chk("clean_data", out_data, 32'h1);
        chk("clean_mask", out_xz_mask, 32'h0);
        chk("clean_flag", out_xz_flag, 1'b0);
        chk("clean_count", xz_count, 16'd0);

        // Backpressure: drain, then hold beat A for 3 cycles with B waiting
        step();
        in_valid = 1'b1; in_data = 32'hA5A5_0003; out_ready = 1'b0;
        step();
        in_data = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_data", out_data, 32'hA5A5_0003);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_data", out_data, 32'h1234_5678);
        chk("bp_second_valid", out_valid, 1'b1);

        // X beat halts intake, clr_err releases
        step();
        in_valid = 1'b1; in_data = 32'hxxxx_0005;
        step();
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        if (four_state) chk("x_data", out_data, 32'h0000_0005);
        chk("x_mask", out_xz_mask, four_state ? 32'hFFFF_0000 : 32'h0);
        chk("x_err", err_sticky, four_state);
        chk("x_count", xz_count, four_state ? 16'd1 : 16'd0);
        chk("x_halted", halted, four_state);
        chk("x_in_ready", in_ready, !four_state);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 1'b1);
        chk("clr_err_low", err_sticky, 1'b0);

        // clr_err coinciding with an accepted X beat: set wins, go to HALT
        step();
        in_valid = 1'b1; in_data = 32'h0000_00x1; clr_err = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; clr_err = 1'b0;
        @(negedge clk);
        chk("coin_halted", halted, four_state);
        chk("coin_err", err_sticky, four_state);
        chk("coin_count", xz_count, four_state ? 16'd2 : 16'd0);
        chk("coin_valid", out_valid, 1'b1);
        step();
        @(negedge clk);
        chk("halt_drained", out_valid, 1'b0);
        chk("halt_kept", halted, four_state);

        // Reset while HALT with a beat held
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hxxxx_xxxx;
        step();
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        chk("pre_rst_halted", halted, four_state);
        chk("pre_rst_valid", out_valid, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 32'h0);
        chk("arst_mask", out_xz_mask, 32'h0);
        chk("arst_err", err_sticky, 1'b0);
        chk("arst_count", xz_count, 16'd0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // u1: clean beat, Z beat with FILL=1
        in_valid1 = 1'b1; in_data1 = 32'h0F0F_0000; out_ready1 = 1'b1;
        step();
        in_data1 = 32'hzzzz_zzzz;
        @(negedge clk);
        chk("u1_clean_data", out_data1, 32'h0F0F_0000);
        chk("u1_clean_mask", out_xz_mask1, 32'h0);
        step();
        in_valid1 = 1'b0; in_data1 = '0;
        @(negedge clk);
        if (four_state) chk("u1_z_data", out_data1, 32'hFFFF_FFFF);
        chk("u1_z_mask", out_xz_mask1, four_state ? 32'hFFFF_FFFF : 32'h0);
        chk("u1_z_flag", out_xz_flag1, four_state);

        // u1: saturation with STOP_ON_XZ=0
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid1 = 1'b1; in_data1 = 32'hx000_000x;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("u1_never_halt", halted1, 1'b0);
            chk("u1_ready", in_ready1, 1'b1);
        end
        in_valid1 = 1'b0; in_data1 = '0;
        @(negedge clk);
        chk("u1_sat_count", xz_count1, four_state ? 2'd3 : 2'd0);
        chk("u1_sat_err", err_sticky1, four_state);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
